fir_xifu_wb: RTL and testbench

Writeback/result stage of the FIR XIFU: the transmitting end of the XIF result interface, returning one result transaction to the CV32E40X for every instruction the XIFU accepted at issue. Completed instructions from EX are buffered in a small in-order FIFO. Each head entry is held until the controller scoreboard reports it committed or killed. Committed entries are offered on `xif_result` with a valid/ready handshake; killed entries are dropped silently.

---
 rtl/fir_xifu_pkg.sv | 40 ++++
 rtl/fir_xifu_wb_fifo.sv | 49 ++++
 rtl/fir_xifu_wb.sv | 154 +++++++++++++++
 tb/tb_fir_xifu_wb.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU writeback/result stage:
// EX/controller payload structs, the FIFO entry layout and the head FSM encoding.
package fir_xifu_pkg;

    localparam int X_ID_WIDTH    = 4;
    localparam int X_ID_NUM      = 2 ** X_ID_WIDTH;
    localparam int WB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic                  valid;
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        logic                  we;
        logic [31:0]           data;
    } ex2wb_t;

    typedef struct packed {
        logic [X_ID_NUM-1:0] commit_mask;
        logic [X_ID_NUM-1:0] kill_mask;
    } ctrl2wb_t;

    typedef struct packed {
        logic                  retire;
        logic [X_ID_WIDTH-1:0] id;
    } wb2ctrl_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        logic                  we;
        logic [31:0]           data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_EMPTY,
        WB_WAIT,
        WB_OFFER
    } wb_state_t;

endpackage

// File: rtl/fir_xifu_wb_fifo.sv
// Generic in-order FIFO of DEPTH entries (DEPTH a power of two, so pointers wrap
// naturally). Control state is reset; the storage array is not.
module fir_xifu_wb_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fir_xifu_wb.sv
// FIR XIFU writeback stage: buffers EX results in order and returns one XIF result
// per committed instruction. Optional same-cycle bypass: FIR_XIFU_RESULT_BYPASS_EN.
module fir_xifu_wb
    import fir_xifu_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  ex2wb_t                ex2wb_i,
    input  ctrl2wb_t              ctrl2wb_i,
    output wb2ctrl_t              wb2ctrl_o,
    output logic                  xif_result_valid_o,
    input  logic                  xif_result_ready_i,
    output logic [X_ID_WIDTH-1:0] xif_result_id_o,
    output logic [31:0]           xif_result_data_o,
    output logic [4:0]            xif_result_rd_o,
    output logic                  xif_result_we_o,
    output logic                  xif_result_exc_o,
    output logic [5:0]            xif_result_exccode_o,
    output logic                  xif_result_err_o,
    output logic                  xif_result_dbg_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_state_t             state;
    wb_state_t             state_next;
    wb_entry_t             head;
    wb_entry_t             in_entry;
    wb_entry_t             out_entry;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_after;
    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  retire;
    logic [X_ID_WIDTH-1:0] retire_id;
    logic                  res_valid;
    logic                  in_commit;
    logic                  in_kill;
    logic                  head_commit;
    logic                  head_kill;

    assign in_entry = '{id: ex2wb_i.id, rd: ex2wb_i.rd, we: ex2wb_i.we, data: ex2wb_i.data};

    // ready_o depends only on the registered count, never on result_ready
    assign ready_o     = !full;
    assign accept      = ex2wb_i.valid && ready_o && !clear_i;
    assign in_commit   = ctrl2wb_i.commit_mask[ex2wb_i.id];
    assign in_kill     = ctrl2wb_i.kill_mask[ex2wb_i.id];
    assign head_commit = !empty && ctrl2wb_i.commit_mask[head.id];
    assign head_kill   = !empty && ctrl2wb_i.kill_mask[head.id];

    fir_xifu_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clear (clear_i),
        .push  (push),
        .wdata (in_entry),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= WB_EMPTY;
        else         state <= state_next;
    end

    always_comb begin
        state_next  = state;
        push        = accept;
        pop         = 1'b0;
        retire      = 1'b0;
        retire_id   = head.id;
        res_valid   = 1'b0;
        out_entry   = head;
        count_after = '0;
        case (state)
            WB_EMPTY: begin
                if (accept) begin
`ifdef FIR_XIFU_RESULT_BYPASS_EN
                    if (in_commit && !in_kill) begin
                        res_valid = 1'b1;
                        out_entry = in_entry;
                        if (xif_result_ready_i) begin
                            push      = 1'b0;
                            retire    = 1'b1;
                            retire_id = in_entry.id;
                        end else begin
                            state_next = WB_OFFER;
                        end
                    end else begin
                        state_next = WB_WAIT;
                    end
`else
                    // an entry already committed at push time skips the WAIT cycle
                    state_next = (in_commit && !in_kill) ? WB_OFFER : WB_WAIT;
`endif
                end
            end
            WB_WAIT: begin
                if (head_kill) begin
                    pop    = 1'b1;
                    retire = 1'b1;
                end else if (head_commit) begin
                    state_next = WB_OFFER;
                end
            end
            WB_OFFER: begin
                res_valid = 1'b1;
                if (xif_result_ready_i) begin
                    pop    = 1'b1;
                    retire = 1'b1;
                end
            end
            default: state_next = WB_EMPTY;
        endcase
        count_after = count + CNT_W'(push) - CNT_W'(pop);
        if (pop) state_next = (count_after == '0) ? WB_EMPTY : WB_WAIT;
        // a flush wins over any pending handshake, so nothing is offered or retired
        if (clear_i) begin
            state_next = WB_EMPTY;
            push       = 1'b0;
            pop        = 1'b0;
            retire     = 1'b0;
            res_valid  = 1'b0;
        end
    end

    assign xif_result_valid_o   = res_valid;
    assign xif_result_id_o      = res_valid ? out_entry.id   : '0;
    assign xif_result_data_o    = res_valid ? out_entry.data : '0;
    assign xif_result_rd_o      = res_valid ? out_entry.rd   : '0;
    assign xif_result_we_o      = res_valid ? out_entry.we   : 1'b0;
    assign xif_result_exc_o     = 1'b0;
    assign xif_result_exccode_o = '0;
    assign xif_result_err_o     = 1'b0;
    assign xif_result_dbg_o     = 1'b0;

    assign wb2ctrl_o.retire = retire;
    assign wb2ctrl_o.id     = retire ? retire_id : '0;

endmodule

// File: tb/tb_fir_xifu_wb.sv
// Bench for fir_xifu_wb: queue-based model of the result stage checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_fir_xifu_wb;
    import fir_xifu_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    ex2wb_t      ex;
    ctrl2wb_t    ctrl;
    wb2ctrl_t    w2c;
    logic        rvalid, rready, rwe, rexc, rerr, rdbg, rdy;
    logic [3:0]  rid;
    logic [4:0]  rrd;
    logic [5:0]  rexccode;
    logic [31:0] rdata;

    fir_xifu_wb #(.DEPTH(DEPTH)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .clear_i              (clear),
        .ex2wb_i              (ex),
        .ctrl2wb_i            (ctrl),
        .wb2ctrl_o            (w2c),
        .xif_result_valid_o   (rvalid),
        .xif_result_ready_i   (rready),
        .xif_result_id_o      (rid),
        .xif_result_data_o    (rdata),
        .xif_result_rd_o      (rrd),
        .xif_result_we_o      (rwe),
        .xif_result_exc_o     (rexc),
        .xif_result_exccode_o (rexccode),
        .xif_result_err_o     (rerr),
        .xif_result_dbg_o     (rdbg),
        .ready_o              (rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        bit          armed;
    } ment_t;

    typedef struct {
        bit          valid;
        bit          retire;
        logic [3:0]  rid;
        bit          rdy;
        bit          push;
        bit          bypass;
        logic [3:0]  vid;
        logic [4:0]  vrd;
        logic        vwe;
        logic [31:0] vdata;
    } exp_t;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } hs_t;

    ment_t      q[$];
    hs_t        hs_log[$];
    logic [3:0] ret_log[$];

    function automatic exp_t predict();
        exp_t e;
        e = '{default: 0};
        e.rdy  = (q.size() < DEPTH);
        e.push = ex.valid && e.rdy && !clear;
        if (clear) return e;
        if (q.size() > 0) begin
            e.rid = q[0].id;
            if (q[0].armed) begin
                e.valid  = 1;
                e.vid    = q[0].id;
                e.vrd    = q[0].rd;
                e.vwe    = q[0].we;
                e.vdata  = q[0].data;
                e.retire = rready;
            end else begin
                e.retire = ctrl.kill_mask[q[0].id];
            end
        end
`ifdef FIR_XIFU_RESULT_BYPASS_EN
        else if (ex.valid && ctrl.commit_mask[ex.id] && !ctrl.kill_mask[ex.id]) begin
            e.valid  = 1;
            e.bypass = 1;
            e.vid    = ex.id;
            e.vrd    = ex.rd;
            e.vwe    = ex.we;
            e.vdata  = ex.data;
            if (rready) begin
                e.retire = 1;
                e.rid    = ex.id;
                e.push   = 0;
            end
        end
`endif
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        exp_t  e;
        ment_t n;
        bit    was_empty;
        if (!rst_n) begin
            q.delete();
        end else if (clear) begin
            q.delete();
        end else begin
            e = predict();
            was_empty = (q.size() == 0);
            if (!was_empty && !q[0].armed && !ctrl.kill_mask[q[0].id] && ctrl.commit_mask[q[0].id])
                q[0].armed = 1;
            if (e.retire && !e.bypass) void'(q.pop_front());
            if (e.push) begin
                n.id    = ex.id;
                n.rd    = ex.rd;
                n.we    = ex.we;
                n.data  = ex.data;
                n.armed = was_empty && ctrl.commit_mask[ex.id] && !ctrl.kill_mask[ex.id];
                q.push_back(n);
            end
        end
    end

    always @(negedge clk) begin : cmp
        exp_t e;
        hs_t  h;
        if (!rst_n) begin
            chk("rst_valid", 32'(rvalid), 32'd0);
            chk("rst_retire", 32'(w2c.retire), 32'd0);
            chk("rst_ready", 32'(rdy), 32'd1);
        end else begin
            e = predict();
            chk("valid", 32'(rvalid), 32'(e.valid));
            chk("ready", 32'(rdy), 32'(e.rdy));
            chk("retire", 32'(w2c.retire), 32'(e.retire));
            if (e.valid) begin
                chk("res_id", 32'(rid), 32'(e.vid));
                chk("res_rd", 32'(rrd), 32'(e.vrd));
                chk("res_we", 32'(rwe), 32'(e.vwe));
                chk("res_data", rdata, e.vdata);
            end
            if (e.retire) chk("retire_id", 32'(w2c.id), 32'(e.rid));
            chk("tied_zero", 32'({rexc, rerr, rdbg, rexccode}), 32'd0);
            if (rvalid && rready) begin
                h.id = rid; h.rd = rrd; h.we = rwe; h.data = rdata;
                hs_log.push_back(h);
            end
            if (w2c.retire) ret_log.push_back(w2c.id);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] id, input logic [4:0] rd, input logic we, input logic [31:0] data);
        ex.valid = 1'b1;
        ex.id    = id;
        ex.rd    = rd;
        ex.we    = we;
        ex.data  = data;
    endtask

    task automatic idle();
        ex = '0;
    endtask

    task automatic wait_hs(input int target, input string name);
        int k;
        k = 0;
        while (hs_log.size() < target && k < 50) begin
            step();
            k++;
        end
        chk({name, "_hs_seen"}, 32'(hs_log.size() >= target), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ex     = '0;
        ctrl   = '0;
        rready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_payload", rdata, 32'd0);
        chk("rst_id", 32'(rid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // single xfirlw, commit one cycle after push
        hs_log.delete(); ret_log.delete();
        rready = 1'b1;
        drive(4'd3, 5'd5, 1'b1, 32'h1000_0004);
        step();
        idle();
        ctrl.commit_mask[3] = 1'b1;
        @(negedge clk);
        chk("t1_wait_no_valid", 32'(rvalid), 32'd0);
        step();
        @(negedge clk);
        chk("t1_valid_n2", 32'(rvalid), 32'd1);
        wait_hs(1, "t1");
        step();
        ctrl = '0;
        chk("t1_hs_count", 32'(hs_log.size()), 32'd1);
        chk("t1_id", 32'(hs_log[0].id), 32'd3);
        chk("t1_rd", 32'(hs_log[0].rd), 32'd5);
        chk("t1_we", 32'(hs_log[0].we), 32'd1);
        chk("t1_data", hs_log[0].data, 32'h1000_0004);
        chk("t1_retire_cnt", 32'(ret_log.size()), 32'd1);
        chk("t1_retire_id", 32'(ret_log[0]), 32'd3);

        // xfirdotp with result_ready low for 5 cycles
        hs_log.delete(); ret_log.delete();
        rready = 1'b0;
        ctrl.commit_mask[1] = 1'b1;
        drive(4'd1, 5'd0, 1'b0, 32'h0000_ABCD);
        step();
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", 32'(rvalid), 32'd1);
            chk("t2_hold_id", 32'(rid), 32'd1);
            chk("t2_hold_data", rdata, 32'h0000_ABCD);
            step();
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        ctrl = '0;
        step();
        chk("t2_hs_count", 32'(hs_log.size()), 32'd1);
        chk("t2_we", 32'(hs_log[0].we), 32'd0);
        chk("t2_retire_id", 32'(ret_log[0]), 32'd1);

        // kill id 2, send id 4
        hs_log.delete(); ret_log.delete();
        rready = 1'b1;
        drive(4'd2, 5'd7, 1'b1, 32'h2222_0000);
        step();
        drive(4'd4, 5'd8, 1'b1, 32'h4444_0000);
        step();
        idle();
        ctrl.kill_mask[2]   = 1'b1;
        ctrl.commit_mask[4] = 1'b1;
        wait_hs(1, "t3");
        step();
        ctrl = '0;
        chk("t3_hs_count", 32'(hs_log.size()), 32'd1);
        chk("t3_hs_id", 32'(hs_log[0].id), 32'd4);
        chk("t3_retire_cnt", 32'(ret_log.size()), 32'd2);
        chk("t3_retire_first", 32'(ret_log[0]), 32'd2);
        chk("t3_retire_second", 32'(ret_log[1]), 32'd4);

        // back-pressure with DEPTH=2
        hs_log.delete(); ret_log.delete();
        rready = 1'b0;
        ctrl.commit_mask[5] = 1'b1;
        ctrl.commit_mask[6] = 1'b1;
        ctrl.commit_mask[0] = 1'b1;
        drive(4'd5, 5'd1, 1'b1, 32'h5);
        step();
        drive(4'd6, 5'd2, 1'b1, 32'h6);
        step();
        drive(4'd0, 5'd3, 1'b0, 32'h7);
        @(negedge clk);
        chk("t4_full", 32'(rdy), 32'd0);
        step();
        rready = 1'b1;
        @(negedge clk);
        chk("t4_full_during_pop", 32'(rdy), 32'd0);
        chk("t4_offer_id", 32'(rid), 32'd5);
        step();
        rready = 1'b0;
        @(negedge clk);
        chk("t4_reopen", 32'(rdy), 32'd1);
        step();
        idle();
        rready = 1'b1;
        wait_hs(3, "t4");
        step();
        ctrl = '0;
        rready = 1'b0;
        chk("t4_hs_count", 32'(hs_log.size()), 32'd3);
        chk("t4_order0", 32'(hs_log[0].id), 32'd5);
        chk("t4_order1", 32'(hs_log[1].id), 32'd6);
        chk("t4_order2", 32'(hs_log[2].id), 32'd0);

        // clear during OFFER
        hs_log.delete(); ret_log.delete();
        ctrl.commit_mask[3] = 1'b1;
        drive(4'd3, 5'd9, 1'b1, 32'h3333);
        step();
        idle();
        @(negedge clk);
        chk("t5_offer", 32'(rvalid), 32'd1);
        step();
        clear = 1'b1;
        @(negedge clk);
        chk("t5_no_retire_clear", 32'(w2c.retire), 32'd0);
        step();
        clear = 1'b0;
        @(negedge clk);
        chk("t5_valid_after", 32'(rvalid), 32'd0);
        chk("t5_ready_after", 32'(rdy), 32'd1);
        step();
        ctrl = '0;
        chk("t5_retire_cnt", 32'(ret_log.size()), 32'd0);

        // asynchronous reset mid-transaction
        ctrl.commit_mask[2] = 1'b1;
        drive(4'd2, 5'd4, 1'b1, 32'hBEEF);
        step();
        idle();
        @(negedge clk);
        chk("t6_offer", 32'(rvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_drop", 32'(rvalid), 32'd0);
        chk("t6_async_ready", 32'(rdy), 32'd1);
        ctrl = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // same-cycle path from EX to the result port
        hs_log.delete(); ret_log.delete();
        rready = 1'b1;
        ctrl.commit_mask[7] = 1'b1;
        drive(4'd7, 5'd6, 1'b1, 32'h7777_0007);
        #1;
`ifdef FIR_XIFU_RESULT_BYPASS_EN
        chk("t7_bypass_valid", 32'(rvalid), 32'd1);
        chk("t7_bypass_id", 32'(rid), 32'd7);
        chk("t7_bypass_retire", 32'(w2c.retire), 32'd1);
        step();
        idle();
        @(negedge clk);
        chk("t7_count_zero", 32'(rdy), 32'd1);
        chk("t7_no_offer", 32'(rvalid), 32'd0);
`else
        chk("t7_no_comb_path", 32'(rvalid), 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("t7_offer_next", 32'(rvalid), 32'd1);
`endif
        step();
        step();
        ctrl = '0;
        rready = 1'b0;
        chk("t7_hs_count", 32'(hs_log.size()), 32'd1);
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
